video_encoder: RTL
==================

VIDEO_ENCODER -- requirements
Module: video_encoder

Interface
REQ-001 SHALL have port i_master_clk, input, 1, single clock; all logic on its rising edge.
REQ-002 SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port i_base_address, input, 18, VRAM word address of the first encoded word of a row.
REQ-004 SHALL have port i_base_address_valid, input, 1, loads i_base_address; honoured only in IDLE.
REQ-005 SHALL have port i_row_start, input, 1, one-cycle pulse in IDLE starting a 512-pixel row.
REQ-006 SHALL have port i_pixel_data, input, 12, pixel colour (RGB444).
REQ-007 SHALL have port i_pixel_valid, input, 1, pixel present.
REQ-008 SHALL have port o_pixel_ready, output, 1, pixel accepted when i_pixel_valid && o_pixel_ready.
REQ-009 SHALL have port o_vram_write_address, output, 18, VRAM word address.
REQ-010 SHALL have port o_vram_write_data, output, 16, encoded word.
REQ-011 SHALL have port o_vram_write_request, output, 1, write request, held until acknowledged.
REQ-012 SHALL have port i_vram_write_done, input, 1, write acknowledge.
REQ-013 SHALL have port o_row_done, output, 1, one-cycle pulse after the final word of a row is acknowledged.
REQ-014 SHALL have port o_busy, output, 1, high whenever state != IDLE.

Function
REQ-015 Word format SHALL be: [15:12]=0 long black, count in [10:0] (1..512), [11] zero; [15:12]=N (1..15) for N pixels of colour [11:0].
REQ-016 States SHALL be IDLE, ACCUM, EMIT, WAIT_ACK, DONE; i_row_start in IDLE -> ACCUM with run empty and pixel count 0.
REQ-017 o_pixel_ready SHALL be high only in ACCUM while accepted pixels < 512.
REQ-018 An accepted pixel SHALL extend the current run if its colour matches and the run is below its limit (15 for counted, 512 for long black); otherwise the current run SHALL be latched as a word, the pixel SHALL start a new run of length 1, and the state SHALL go to EMIT.
REQ-019 On acceptance of pixel 512, the current run (including that pixel) SHALL be emitted; if pixel 512 broke a run, two words SHALL be emitted in order.
REQ-020 EMIT SHALL assert o_vram_write_request in the next cycle with address and data stable until i_vram_write_done; request SHALL drop the cycle after acknowledge.
REQ-021 After each acknowledge, the address SHALL increment by 1 (mod 2^18) and the state SHALL return to ACCUM, or to EMIT if a final run remains, or to DONE if the row is complete.
REQ-022 DONE SHALL pulse o_row_done for one cycle and return to IDLE; the address SHALL persist so that consecutive rows pack contiguously unless reloaded.
REQ-023 i_row_start outside IDLE and i_base_address_valid outside IDLE SHALL be ignored; if both are asserted in the same IDLE cycle, the new base SHALL apply to that row.
REQ-024 An acknowledge arriving in the same cycle as the request is first asserted SHALL be accepted (zero-wait VRAM).

Reset
REQ-025 i_reset SHALL force IDLE, address 0, run empty, and all outputs 0 on the next edge, aborting any pending write.

Configuration
REQ-026 With VIDEO_ENCODER_LONG_BLACK_EN defined, black (0x000) runs SHALL use the long-black form (limit 512); without it, black SHALL be encoded as a counted colour 0x000 (limit 15) and [15:12]=0 words SHALL never be produced.

Verification
REQ-027 Macro on, base 0x00100, 512 x 0x000 -> one write 0x0200 at 0x00100, o_row_done once.
REQ-028 512 x 0xABC -> 34 writes 0xFABC then 0x2ABC, at addresses 0x00100..0x00122.
REQ-029 Alternating 0x123/0x456, acknowledge delayed 3 cycles -> 512 writes 0x1123/0x1456 alternating; o_pixel_ready low during every wait; request never drops before acknowledge.
REQ-030 511 x 0xFFF then 0x001 -> 34 x 0xFFFF, 0x1FFF, 0x1001 (36 writes).
REQ-031 Macro off, 512 x 0x000 -> 34 x 0xF000 then 0x2000.
REQ-032 i_reset during WAIT_ACK -> request low, o_busy low the next cycle; a subsequent i_row_start encodes a fresh row from address 0.

Source files
------------

// File: rtl/video_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : video_encoder
//  Purpose  : Run-length encodes one 512-pixel RGB444 row into 16-bit VRAM
//             words and writes them to consecutive VRAM word addresses.
//             Word layout:
//               [15:12] = N (1..15) : N pixels of colour [11:0]
//               [15:12] = 0         : long black run, count (1..512) in [10:0]
//             Long-black words exist only when VIDEO_ENCODER_LONG_BLACK_EN
//             is defined. Otherwise black is an ordinary counted colour.
//  Ports    : i_master_clk          - clock, rising edge
//             i_reset               - synchronous active-high reset
//             i_base_address[17:0]  - first word address of a row
//             i_base_address_valid  - loads i_base_address (IDLE only)
//             i_row_start           - starts a row (IDLE only)
//             i_pixel_data[11:0]    - pixel colour
//             i_pixel_valid         - pixel present
//             o_pixel_ready         - pixel accepted when valid && ready
//             o_vram_write_address  - VRAM word address
//             o_vram_write_data     - encoded word
//             o_vram_write_request  - held until i_vram_write_done
//             i_vram_write_done     - write acknowledge
//             o_row_done            - one-cycle pulse at end of row
//             o_busy                - high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module video_encoder (
    input  logic        i_master_clk,
    input  logic        i_reset,
    input  logic [17:0] i_base_address,
    input  logic        i_base_address_valid,
    input  logic        i_row_start,
    input  logic [11:0] i_pixel_data,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    output logic [17:0] o_vram_write_address,
    output logic [15:0] o_vram_write_data,
    output logic        o_vram_write_request,
    input  logic        i_vram_write_done,
    output logic        o_row_done,
    output logic        o_busy
);

`ifdef VIDEO_ENCODER_LONG_BLACK_EN
    localparam logic c_LONG_BLACK_EN = 1'b1;
`else
    localparam logic c_LONG_BLACK_EN = 1'b0;
`endif

    localparam logic [9:0] c_ROW_PIXELS    = 10'd512;
    localparam logic [9:0] c_LAST_PIXEL    = 10'd511;
    localparam logic [9:0] c_COUNTED_LIMIT = 10'd15;
    localparam logic [9:0] c_BLACK_LIMIT   = 10'd512;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACCUM    = 3'd1,
        S_EMIT     = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [17:0] r_addr;
    logic [15:0] r_data;
    logic [11:0] r_run_color;
    logic [9:0]  r_run_len;     // 0 means no run in progress
    logic [9:0]  r_pix_cnt;     // pixels accepted in this row
    logic        r_flush;       // a final run still has to follow the current word
    logic        r_last;        // the current word is the last one of the row

    logic        w_ready;
    logic        w_accept;
    logic        w_run_black;
    logic [9:0]  w_run_limit;
    logic        w_extend;
    logic        w_break;
    logic        w_last_pixel;

    function automatic logic [15:0] encode(input logic [11:0] color,
                                           input logic [9:0]  len);
        if (c_LONG_BLACK_EN && (color == 12'h000))
            encode = {6'b000000, len};
        else
            encode = {len[3:0], color};
    endfunction

    // ------------------------------------------------------------------
    // Next-state and run classification
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_run_black  = c_LONG_BLACK_EN && (r_run_color == 12'h000);
        w_run_limit  = w_run_black ? c_BLACK_LIMIT : c_COUNTED_LIMIT;
        w_extend     = (r_run_len != 10'd0) && (i_pixel_data == r_run_color) &&
                       (r_run_len < w_run_limit);
        // A non-empty run that cannot absorb the pixel must be written out.
        w_break      = (r_run_len != 10'd0) && !w_extend;
        w_last_pixel = (r_pix_cnt == c_LAST_PIXEL);
        w_ready      = (r_state == S_ACCUM) && (r_pix_cnt < c_ROW_PIXELS);
        w_accept     = w_ready && i_pixel_valid;

        case (r_state)
            S_IDLE: begin
                if (i_row_start)
                    w_next_state = S_ACCUM;
            end
            S_ACCUM: begin
                if (w_accept && (w_break || w_last_pixel))
                    w_next_state = S_EMIT;
            end
            S_EMIT: begin
                w_next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (i_vram_write_done) begin
                    if (r_flush)
                        w_next_state = S_EMIT;
                    else if (r_last)
                        w_next_state = S_DONE;
                    else
                        w_next_state = S_ACCUM;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_master_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // Datapath: run tracking, word latch, address counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_master_clk) begin
        if (i_reset) begin
            r_addr      <= 18'd0;
            r_data      <= 16'd0;
            r_run_color <= 12'd0;
            r_run_len   <= 10'd0;
            r_pix_cnt   <= 10'd0;
            r_flush     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A base load in the same cycle as row start applies to that row.
                    if (i_base_address_valid)
                        r_addr <= i_base_address;
                    if (i_row_start) begin
                        r_pix_cnt <= 10'd0;
                        r_run_len <= 10'd0;
                        r_flush   <= 1'b0;
                        r_last    <= 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_pix_cnt <= r_pix_cnt + 10'd1;
                        if (w_extend) begin
                            r_run_len <= r_run_len + 10'd1;
                        end else begin
                            r_run_color <= i_pixel_data;
                            r_run_len   <= 10'd1;
                        end
                        if (w_break) begin
                            // Old run goes out now; on the last pixel the
                            // fresh one-pixel run follows as a second word.
                            r_data  <= encode(r_run_color, r_run_len);
                            r_flush <= w_last_pixel;
                        end else if (w_last_pixel) begin
                            r_data <= w_extend ? encode(r_run_color, r_run_len + 10'd1)
                                               : encode(i_pixel_data, 10'd1);
                            r_last <= 1'b1;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (i_vram_write_done) begin
                        r_addr <= r_addr + 18'd1;
                        if (r_flush) begin
                            r_data  <= encode(r_run_color, r_run_len);
                            r_flush <= 1'b0;
                            r_last  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_last <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_pixel_ready        = w_ready;
    assign o_vram_write_address = r_addr;
    assign o_vram_write_data    = r_data;
    assign o_vram_write_request = (r_state == S_WAIT_ACK);
    assign o_row_done           = (r_state == S_DONE);
    assign o_busy               = (r_state != S_IDLE);

endmodule
`default_nettype wire
